mul3_seq_ctrl: RTL and testbench
================================

# mul3_seq_ctrl

Multi-cycle shift-and-add controller that computes an unsigned WIDTH×WIDTH product using a single shared WIDTH-bit adder instead of the parallel adder array. It captures operands on a start pulse and drives the external adder with one partial-product addition per cycle. After WIDTH steps it presents a 2·WIDTH-bit product with a one-cycle done strobe. It sits between the operand source and the existing WIDTH-bit adder (the `a`/`b` → `{cout,sum}` unit), which it instantiates externally through the `add_*` ports.

## Interface

- WIDTH, 3, operand width; product is 2·WIDTH bits; step counter sized to hold WIDTH-1.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, captured when start is accepted
- b  in  WIDTH  multiplier, captured when start is accepted
- busy  out  1  high while in CALC
- done  out  1  one-cycle completion strobe (state DONE)
- product  out  2·WIDTH  registered result, held until next completion
- add_a  out  WIDTH  adder operand A
- add_b  out  WIDTH  adder operand B
- add_sum  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out

## Operation

- Registers: mcand (WIDTH), acc (WIDTH), mplr (WIDTH), cnt, state, product.
- States: IDLE, CALC, DONE.
- IDLE with start=1: mcand←a, mplr←b, acc←0, cnt←0, go to CALC. IDLE with start=0: stay.
- CALC, every cycle:
  - add_a=acc; add_b = mplr[0] ? mcand : 0.
  - {acc,mplr} ← {add_cout, add_sum, mplr} >> 1. The carry becomes acc MSB, sum LSB shifts into mplr MSB.
  - cnt←cnt+1.
  - When cnt==WIDTH-1, product ← {add_cout, add_sum, mplr[WIDTH-1:1]} (the post-shift {acc,mplr}) and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- start in CALC is ignored. a/b changes after acceptance do not affect the result.
- add_a/add_b are driven to 0 in IDLE and DONE. add_sum/add_cout are ignored outside CALC.
- Arithmetic is unsigned. The result is exact: {cout,sum} never overflows WIDTH+1 bits, and the final {acc,mplr} equals a·b in 2·WIDTH bits.
- Reset (any state, including mid-CALC): state=IDLE, busy=0, done=0, product=0, add_a=0, add_b=0, acc/mplr/mcand/cnt=0. The in-flight operation is discarded with no done.

## Timing

- busy = (state==CALC); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- With start high in cycle 0 (state IDLE):
  - busy is high in cycles 1..WIDTH.
  - done and the new product appear in cycle WIDTH+1 (cycle 4 for WIDTH=3).
- Latency from start to done is WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 cycles. With start held high continuously, a new operation is accepted every WIDTH+2 cycles (cycles 0, 5, 10 for WIDTH=3).
- product changes only at the edge entering DONE (or at reset). It is stable through DONE, IDLE and the next CALC.
- The adder path is combinational within one cycle: add_a/add_b → add_sum/add_cout → acc/mplr D-inputs.

## Test plan

- Reset, then start with a=7, b=7 in cycle 0 → busy=1 in cycles 1-3, done=1 only in cycle 4, product=49 (6'b110001), busy=0 in cycle 4.
- a=5, b=3 → product=15. Then a=0, b=6 → product=0. Then a=6, b=0 → product=0. Product holds its previous value between operations.
- During CALC, pulse start and change a/b to 1/1 → ignored; the in-flight result is still correct, and no extra operation runs after done.
- Hold start=1 continuously with a=3, b=2 → done pulses in cycles 4, 9, 14, product=6 each time. Check add_a/add_b=0 in IDLE/DONE cycles.
- Assert rst in cycle 2 of an operation (a=7, b=5) → next cycle busy=0, done=0, product=0, and no done follows. A fresh start with a=2, b=3 gives product=6.
- Exhaustive: all 64 (a,b) pairs back-to-back against a reference model → product==a·b every time, done one cycle wide, busy width exactly 3 cycles.

Source files
------------

// File: rtl/mul3_seq_ctrl_if.sv
// Operand/result handshake and external-adder hookup for the shift-and-add multiplier.
// master = operand source plus shared adder; slave = the sequencer.
interface mul3_seq_ctrl_if #(
    parameter int WIDTH = 3
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    modport master (
        output start, a, b, add_sum, add_cout,
        input  busy, done, product, add_a, add_b
    );

    modport slave (
        input  start, a, b, add_sum, add_cout,
        output busy, done, product, add_a, add_b
    );
endinterface

// File: rtl/mul3_seq_ctrl.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier sequencer driving one shared external WIDTH-bit adder.
// Latency: start accepted in IDLE -> done/product WIDTH+1 cycles later; start-to-start spacing WIDTH+2.
// Backpressure: none; start is ignored outside IDLE, so the source must hold or re-issue it.
module mul3_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    mul3_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mplr;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic                 last_step;
    logic [2*WIDTH-1:0]   shifted;

    assign last_step = (cnt == CW'(WIDTH - 1));
    // Carry lands in acc MSB; the sum LSB shifts down into mplr MSB.
    assign shifted   = {bus.add_cout, bus.add_sum, mplr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.add_a = '0;
        bus.add_b = '0;
        case (state)
            CALC: begin
                bus.busy  = 1'b1;
                bus.add_a = acc;
                bus.add_b = mplr[0] ? mcand : '0;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            acc       <= '0;
            mplr      <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        mplr  <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    {acc, mplr} <= shifted;
                    cnt         <= cnt + CW'(1);
                    if (last_step) begin
                        product_q <= shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_q;
endmodule

// File: tb/tb_mul3_seq_ctrl.sv
// Directed bench for mul3_seq_ctrl; the bench supplies the shared adder combinationally.
module tb_mul3_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mul3_seq_ctrl_if #(.WIDTH(3)) bus ();

    mul3_seq_ctrl #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle (cycle 0); returns in cycle 8 with per-cycle traces.
    task automatic run_op(input logic [2:0] ia, input logic [2:0] ib,
                          output logic [8:0] bm, output logic [8:0] dm, output logic [8:0] zm,
                          output logic [8:0][2:0] tra, output logic [8:0][2:0] trb,
                          output logic [5:0] p_before, output logic [5:0] p_done);
        bm = '0; dm = '0; zm = '0; tra = '0; trb = '0; p_before = '0; p_done = '0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            if (c == 0) begin
                bus.start = 1'b1; bus.a = ia; bus.b = ib;
            end
            if (c == 1) begin
                bus.start = 1'b0;
                bus.a = 3'($urandom_range(7, 0));
                bus.b = 3'($urandom_range(7, 0));
            end
            bm[c]  = bus.busy;
            dm[c]  = bus.done;
            zm[c]  = !bus.busy && ((bus.add_a != 3'd0) || (bus.add_b != 3'd0));
            tra[c] = bus.add_a;
            trb[c] = bus.add_b;
            if (c == 3) p_before = bus.product;
            if (c == 4) p_done = bus.product;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.a = 3'd0; bus.b = 3'd0;
        tick(); tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.product !== 6'd0) begin fails++; $display("FAIL reset_product: got %0d expected 0", bus.product); end
        tests++; if (bus.add_a !== 3'd0) begin fails++; $display("FAIL reset_add_a: got %0d expected 0", bus.add_a); end
        tests++; if (bus.add_b !== 3'd0) begin fails++; $display("FAIL reset_add_b: got %0d expected 0", bus.add_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [8:0] bm, dm, zm;
        logic [8:0][2:0] tra, trb;
        logic [5:0] pb, pd;
        run_op(3'd7, 3'd7, bm, dm, zm, tra, trb, pb, pd);
        tests++; if (bm !== 9'h00E) begin fails++; $display("FAIL basic_busy: got %b expected %b", bm, 9'h00E); end
        tests++; if (dm !== 9'h010) begin fails++; $display("FAIL basic_done: got %b expected %b", dm, 9'h010); end
        tests++; if (pd !== 6'd49) begin fails++; $display("FAIL basic_product: got %0d expected 49", pd); end
        tests++; if (zm !== 9'h000) begin fails++; $display("FAIL basic_adder_idle_zero: got %b expected 0", zm); end
        tests++; if (tra[3:1] !== {3'd5, 3'd3, 3'd0}) begin fails++; $display("FAIL basic_add_a_trace: got %h expected %h", tra[3:1], {3'd5, 3'd3, 3'd0}); end
        tests++; if (trb[3:1] !== {3'd7, 3'd7, 3'd7}) begin fails++; $display("FAIL basic_add_b_trace: got %h expected %h", trb[3:1], {3'd7, 3'd7, 3'd7}); end
    endtask

    task automatic test_vectors();
        logic [8:0] bm, dm, zm;
        logic [8:0][2:0] tra, trb;
        logic [5:0] pb, pd;
        run_op(3'd5, 3'd3, bm, dm, zm, tra, trb, pb, pd);
        tests++; if (pb !== 6'd49) begin fails++; $display("FAIL vec53_hold: got %0d expected 49", pb); end
        tests++; if (pd !== 6'd15) begin fails++; $display("FAIL vec53_product: got %0d expected 15", pd); end
        run_op(3'd0, 3'd6, bm, dm, zm, tra, trb, pb, pd);
        tests++; if (pb !== 6'd15) begin fails++; $display("FAIL vec06_hold: got %0d expected 15", pb); end
        tests++; if (pd !== 6'd0) begin fails++; $display("FAIL vec06_product: got %0d expected 0", pd); end
        tests++; if (dm !== 9'h010) begin fails++; $display("FAIL vec06_done: got %b expected %b", dm, 9'h010); end
        run_op(3'd6, 3'd0, bm, dm, zm, tra, trb, pb, pd);
        tests++; if (pd !== 6'd0) begin fails++; $display("FAIL vec60_product: got %0d expected 0", pd); end
        tests++; if (bus.product !== 6'd0) begin fails++; $display("FAIL vec60_hold_after: got %0d expected 0", bus.product); end
    endtask

    task automatic test_ignore_start();
        logic [10:0] dm;
        logic [5:0]  pd;
        dm = '0; pd = '0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 0) begin bus.start = 1'b1; bus.a = 3'd6; bus.b = 3'd5; end
            if (c == 1) bus.start = 1'b0;
            if (c == 2) begin bus.start = 1'b1; bus.a = 3'd1; bus.b = 3'd1; end
            if (c == 3) bus.start = 1'b0;
            dm[c] = bus.done;
            if (c == 4) pd = bus.product;
        end
        tests++; if (pd !== 6'd30) begin fails++; $display("FAIL ignore_product: got %0d expected 30", pd); end
        tests++; if (dm !== 11'h010) begin fails++; $display("FAIL ignore_done: got %b expected %b", dm, 11'h010); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bm, dm, zm;
        bm = '0; dm = '0; zm = '0;
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) tick();
            if (c == 0) begin bus.start = 1'b1; bus.a = 3'd3; bus.b = 3'd2; end
            if (c == 14) bus.start = 1'b0;
            bm[c] = bus.busy;
            dm[c] = bus.done;
            zm[c] = !bus.busy && ((bus.add_a != 3'd0) || (bus.add_b != 3'd0));
            if (c == 4 || c == 9 || c == 14) begin
                tests++;
                if (bus.product !== 6'd6) begin fails++; $display("FAIL b2b_product_c%0d: got %0d expected 6", c, bus.product); end
            end
        end
        tests++; if (dm !== 20'h04210) begin fails++; $display("FAIL b2b_done: got %h expected %h", dm, 20'h04210); end
        tests++; if (bm !== 20'h039CE) begin fails++; $display("FAIL b2b_busy: got %h expected %h", bm, 20'h039CE); end
        tests++; if (zm !== 20'h00000) begin fails++; $display("FAIL b2b_adder_idle_zero: got %h expected 0", zm); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] bm, dm, zm;
        logic [8:0][2:0] tra, trb;
        logic [5:0] pb, pd;
        logic [10:0] late_done;
        late_done = '0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 0) begin bus.start = 1'b1; bus.a = 3'd7; bus.b = 3'd5; end
            if (c == 1) bus.start = 1'b0;
            if (c == 2) begin
                tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); end
                rst = 1'b1;
            end
            if (c == 3) begin
                rst = 1'b0;
                tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
                tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
                tests++; if (bus.product !== 6'd0) begin fails++; $display("FAIL rstmid_product: got %0d expected 0", bus.product); end
                tests++; if (bus.add_b !== 3'd0) begin fails++; $display("FAIL rstmid_add_b: got %0d expected 0", bus.add_b); end
            end
            late_done[c] = bus.done;
        end
        tests++; if (late_done !== 11'h000) begin fails++; $display("FAIL rstmid_no_done: got %b expected 0", late_done); end
        run_op(3'd2, 3'd3, bm, dm, zm, tra, trb, pb, pd);
        tests++; if (pd !== 6'd6) begin fails++; $display("FAIL rstmid_fresh_product: got %0d expected 6", pd); end
        tests++; if (dm !== 9'h010) begin fails++; $display("FAIL rstmid_fresh_done: got %b expected %b", dm, 9'h010); end
    endtask

    task automatic test_exhaustive();
        logic [8:0] bm, dm, zm;
        logic [8:0][2:0] tra, trb;
        logic [5:0] pb, pd, exp_p;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                exp_p = 6'(i * j);
                run_op(3'(i), 3'(j), bm, dm, zm, tra, trb, pb, pd);
                tests++; if (pd !== exp_p) begin fails++; $display("FAIL exh_product %0dx%0d: got %0d expected %0d", i, j, pd, exp_p); end
                tests++; if (dm !== 9'h010) begin fails++; $display("FAIL exh_done %0dx%0d: got %b expected %b", i, j, dm, 9'h010); end
                tests++; if (bm !== 9'h00E) begin fails++; $display("FAIL exh_busy %0dx%0d: got %b expected %b", i, j, bm, 9'h00E); end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = 3'd0; bus.b = 3'd0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
